// File: rtl/sdspi_sweep_sequencer.sv
// sdspi_sweep_sequencer
//
// Drives repeated runs of the SD-SPI read system under test across every
// combination of block count (1..n_blocks_max), SCLK speed (0..speed_max)
// and CMD18 mode (0, 1). For each run it holds the system under test in
// reset with the SPI pins handed over, pulses start, counts clock cycles
// until uut_finish, and offers one result record over valid/ready.
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   defined   -> a run that has not finished after TIMEOUT_CYCLES cycles is
//                aborted and reported with res_timeout=1
//   undefined -> runs wait for uut_finish forever; res_timeout is tied to 0
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   go                        start a sweep (only looked at while idle)
//   n_blocks_max, speed_max   sweep bounds, captured when go is accepted
//   busy, done                sweep in progress / one-cycle completion pulse
//   uut_ctrl_mux              1 while the system under test owns the SPI pins
//   uut_rst, uut_start        reset and start pulse to the system under test
//   uut_n_blocks,
//   uut_sclk_speed, uut_cmd18 parameters of the current run
//   uut_finish                run-complete level from the system under test
//   res_valid, res_ready      result record handshake
//   res_cycles, res_timeout   measured run length, timeout flag
module sdspi_sweep_sequencer #(
  parameter int N_BLOCK_SIZE    = 32,
  parameter int SCLK_SPEED_SIZE = 5,
  parameter int CMD18_SIZE      = 1,
  parameter int CNT_W           = 32,
  parameter int RST_CYCLES      = 16,
  parameter int TIMEOUT_CYCLES  = 100000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic [N_BLOCK_SIZE-1:0]    n_blocks_max,
  input  logic [SCLK_SPEED_SIZE-1:0] speed_max,
  output logic                       busy,
  output logic                       done,
  output logic                       uut_ctrl_mux,
  output logic                       uut_rst,
  output logic                       uut_start,
  output logic [N_BLOCK_SIZE-1:0]    uut_n_blocks,
  output logic [SCLK_SPEED_SIZE-1:0] uut_sclk_speed,
  output logic [CMD18_SIZE-1:0]      uut_cmd18,
  input  logic                       uut_finish,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [CNT_W-1:0]           res_cycles,
  output logic                       res_timeout
);

  typedef enum logic [2:0] {
    IDLE, LOAD, HOLD_RST, START, RUN, REPORT, NEXT, DONE
  } state_t;

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  state_t                     state_reg, state_next;
  logic [N_BLOCK_SIZE-1:0]    nmax_reg;
  logic [SCLK_SPEED_SIZE-1:0] smax_reg;
  logic [N_BLOCK_SIZE-1:0]    nb_reg;
  logic [SCLK_SPEED_SIZE-1:0] speed_reg;
  logic [CMD18_SIZE-1:0]      cmd18_reg;
  logic [HOLD_W-1:0]          hold_cnt_reg;
  logic [CNT_W-1:0]           cnt_reg;
  logic [CNT_W-1:0]           cnt_inc;
  logic [CNT_W-1:0]           res_cycles_reg;
  logic                       timeout_hit;
  logic                       speed_wrap;
  logic                       nb_wrap;
  logic                       sweep_last;

  // Saturating increment, shared by the running counter and the
  // finish-time latch (which reports counter+1).
  assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;

  assign speed_wrap = (speed_reg >= smax_reg);
  assign nb_wrap    = (nb_reg >= nmax_reg);
  assign sweep_last = speed_wrap && nb_wrap && (cmd18_reg != '0);

`ifdef SEQ_TIMEOUT_EN
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
  // The limit only matters when the timeout feature is built in.
  logic unused_timeout_limit;
  assign unused_timeout_limit = (TIMEOUT_CYCLES > 0);
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (go) state_next = (n_blocks_max == '0) ? DONE : LOAD;
      LOAD:     state_next = HOLD_RST;
      HOLD_RST: if (hold_cnt_reg == HOLD_LAST) state_next = START;
      START:    state_next = RUN;
      RUN:      if (uut_finish || timeout_hit) state_next = REPORT;
      REPORT:   if (res_ready) state_next = NEXT;
      NEXT:     state_next = sweep_last ? DONE : HOLD_RST;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmax_reg       <= '0;
      smax_reg       <= '0;
      nb_reg         <= N_BLOCK_SIZE'(1);
      speed_reg      <= '0;
      cmd18_reg      <= '0;
      hold_cnt_reg   <= '0;
      cnt_reg        <= '0;
      res_cycles_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (go) begin
            nmax_reg <= n_blocks_max;
            smax_reg <= speed_max;
          end
        end
        LOAD: begin
          nb_reg       <= N_BLOCK_SIZE'(1);
          speed_reg    <= '0;
          cmd18_reg    <= '0;
          hold_cnt_reg <= '0;
        end
        HOLD_RST: hold_cnt_reg <= hold_cnt_reg + 1'b1;
        START:    cnt_reg <= '0;
        RUN: begin
          cnt_reg <= cnt_inc;
          // A finish in the same cycle as the timeout limit takes priority.
          if (uut_finish)       res_cycles_reg <= cnt_inc;
          else if (timeout_hit) res_cycles_reg <= CNT_W'(TIMEOUT_CYCLES);
        end
        NEXT: begin
          hold_cnt_reg <= '0;
          // speed innermost, then block count, then CMD18 mode
          if (!speed_wrap) begin
            speed_reg <= speed_reg + 1'b1;
          end else begin
            speed_reg <= '0;
            if (!nb_wrap) begin
              nb_reg <= nb_reg + 1'b1;
            end else begin
              nb_reg <= N_BLOCK_SIZE'(1);
              if (cmd18_reg == '0) cmd18_reg <= CMD18_SIZE'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic res_timeout_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_timeout_reg <= 1'b0;
    end else if (state_reg == RUN) begin
      if (uut_finish)       res_timeout_reg <= 1'b0;
      else if (timeout_hit) res_timeout_reg <= 1'b1;
    end
  end
  assign res_timeout = res_timeout_reg;
`else
  assign res_timeout = 1'b0;
`endif

  // ------------------------------------------------------------- outputs
  // Control outputs decode straight from the state so an asynchronous reset
  // hands the pins back and drops any pending record in the same cycle.
  assign busy           = (state_reg != IDLE);
  assign done           = (state_reg == DONE);
  assign uut_ctrl_mux   = (state_reg == HOLD_RST) || (state_reg == START) || (state_reg == RUN);
  assign uut_rst        = !((state_reg == START) || (state_reg == RUN));
  assign uut_start      = (state_reg == START);
  assign res_valid      = (state_reg == REPORT);
  assign res_cycles     = res_cycles_reg;
  assign uut_n_blocks   = nb_reg;
  assign uut_sclk_speed = speed_reg;
  assign uut_cmd18      = cmd18_reg;

endmodule

// File: doc/sdspi_sweep_sequencer.md
# sdspi_sweep_sequencer

Sequences repeated runs of the SD-SPI read system under test across a sweep of parameter sets. Inputs are the sweep bounds; the swept parameters are block count, SCLK speed and CMD18 mode. For each run the block:
- holds the system under test in reset;
- hands it the SPI pins;
- pulses start;
- times the run in clock cycles;
- presents one result record per run over a valid/ready handshake.

It sits between the autotest controller, which owns the SPI pins otherwise and consumes the results, and the system under test.

## Interface
- N_BLOCK_SIZE, 32, width of the block-count parameter
- SCLK_SPEED_SIZE, 5, width of the SCLK speed selector
- CMD18_SIZE, 1, width of the CMD18 mode field; only values 0 and 1 are swept
- CNT_W, 32, width of the cycle counter
- RST_CYCLES, 16, cycles the system under test is held in reset before each run (≥1)
- TIMEOUT_CYCLES, 100000000, run abort threshold (used only with SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- go  in  1  one-cycle request to start a sweep; sampled only in IDLE
- n_blocks_max  in  N_BLOCK_SIZE  last block count in the sweep (sweep runs 1..n_blocks_max)
- speed_max  in  SCLK_SPEED_SIZE  last SCLK speed in the sweep (sweep runs 0..speed_max)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the sweep completes
- uut_ctrl_mux  out  1  1 = SPI pins driven by the system under test
- uut_rst  out  1  reset to the system under test
- uut_start  out  1  start pulse to the system under test
- uut_n_blocks  out  N_BLOCK_SIZE  current block count
- uut_sclk_speed  out  SCLK_SPEED_SIZE  current speed
- uut_cmd18  out  CMD18_SIZE  current mode
- uut_finish  in  1  run-complete level from the system under test
- res_valid  out  1  result record available
- res_ready  in  1  consumer accepts the record
- res_cycles  out  CNT_W  measured run length
- res_timeout  out  1  the run was aborted by timeout

## Operation
States: IDLE, LOAD, HOLD_RST, START, RUN, REPORT, NEXT, DONE.

- **IDLE**
  - go=1 and n_blocks_max=0: go to DONE; no run is performed.
  - go=1 otherwise: capture n_blocks_max and speed_max into internal registers; go to LOAD. Later changes to the inputs do not affect the sweep in progress.
- **LOAD:** set n_blocks=1, speed=0, cmd18=0; go to HOLD_RST.
- **HOLD_RST:** uut_rst=1, uut_ctrl_mux=1 for exactly RST_CYCLES cycles; then go to START.
- **START:**
  - uut_rst=0, uut_start=1 for exactly one cycle.
  - Cycle counter cleared to 0.
  - Go to RUN.
- **RUN:**
  - Counter increments each cycle, saturating at all-ones.
  - uut_finish=1: latch res_cycles = counter + 1 (saturated) and res_timeout=0; go to REPORT.
- **REPORT:**
  - res_valid=1; uut_ctrl_mux=0; uut_rst=1.
  - res_cycles and res_timeout hold stable until res_valid && res_ready, then go to NEXT.
- **NEXT:** advance the parameters in this order.
  - speed innermost, then n_blocks, then cmd18 outermost.
  - speed < speed_max: speed+1. Otherwise speed=0, then:
    - n_blocks < n_blocks_max: n_blocks+1.
    - Otherwise n_blocks=1, then:
      - cmd18=0: cmd18=1.
      - Otherwise go to DONE.
  - Any other advance: go to HOLD_RST.
- **DONE:** done=1 for one cycle; go to IDLE.
- Total runs per sweep = 2 × n_blocks_max × (speed_max+1).
- uut_n_blocks, uut_sclk_speed and uut_cmd18 are registered and constant from HOLD_RST through REPORT of each run.

## Timing
- **Reset values:**
  - Outputs: busy=0, done=0, uut_ctrl_mux=0, uut_rst=1, uut_start=0, res_valid=0, res_timeout=0.
  - Parameter outputs: uut_n_blocks=1, uut_sclk_speed=0, uut_cmd18=0.
  - res_cycles=0; state=IDLE.
- **Reset mid-sweep:** immediate return to reset values. Any pending record is discarded, and the SPI pins return to the autotest controller.
- go → first uut_rst deassertion: 2+RST_CYCLES cycles.
- **uut_finish already 1 in the first RUN cycle:** res_cycles=1.
- uut_finish is ignored outside RUN.
- go while busy is ignored.
- **res_ready during REPORT:**
  - Held high: REPORT lasts one cycle.
  - Held low: REPORT stalls indefinitely. The system under test stays in reset and the counter is frozen.
- uut_ctrl_mux is 1 exactly in HOLD_RST, START and RUN.

## Configuration
- **SEQ_TIMEOUT_EN defined:**
  - In RUN, if the counter reaches TIMEOUT_CYCLES-1 with uut_finish=0, latch res_cycles=TIMEOUT_CYCLES and res_timeout=1; go to REPORT.
  - If uut_finish=1 in that same cycle, finish wins: res_timeout=0.
- **SEQ_TIMEOUT_EN undefined:**
  - RUN waits indefinitely.
  - res_timeout is constant 0; TIMEOUT_CYCLES is unused.

## Test plan
- **Single run:** n_blocks_max=1, speed_max=0, go; model finishes 50 cycles after start.
  - Expect 2 records, each res_cycles=50, with cmd18 0 then 1.
  - Expect done one cycle after the second handshake.
- **Sweep order:** n_blocks_max=2, speed_max=1 → 8 records. (n_blocks, speed, cmd18) sequence: (1,0,0), (1,1,0), (2,0,0), (2,1,0), (1,0,1), (1,1,1), (2,0,1), (2,1,1).
- **Backpressure:** res_ready low for 20 cycles in REPORT.
  - res_valid and data stay stable; uut_rst=1; uut_ctrl_mux=0.
  - Advance occurs on the cycle after ready rises.
- **Timeout (SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100):** model never finishes.
  - Every record has res_timeout=1 and res_cycles=100.
  - The sweep still completes.
- **Reset and ignored go:**
  - Assert rst during RUN of the third run: all outputs return to reset values in the same cycle.
  - go pulsed while busy has no effect.
- **Zero sweep:** n_blocks_max=0, go → done pulse 1 cycle later; no uut_start and no record.
